// File: rtl/render_pkg.sv
// Shared render types, scheduler states and lane encoding.
// Also hosts the round-robin pick helpers used by dispatch and arbiter.
package render_pkg;

  typedef logic [31:0] q16_16_t;
  typedef logic [11:0] color12_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  len;
    q16_16_t     depth;
    color12_t    color;
  } triangle_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DRAW,
    S_DRAIN
  } sched_state_e;

  localparam q16_16_t CLEAR_DEPTH_DEF = 32'h7FFF_FFFF;

  // out_lane: 0 is the filler, lane k reports as k+LANE_BASE
  localparam int unsigned LANE_FILLER = 0;
  localparam int unsigned LANE_BASE   = 1;

  function automatic logic [2:0] rr_first(
    input logic [7:0] req,
    input logic [2:0] ptr,
    input int         n
  );
    int         idx;
    logic [2:0] pick;
    pick = ptr;
    for (int i = 7; i >= 0; i--) begin
      if (i < n) begin
        idx = int'(ptr) + i;
        if (idx >= n) idx = idx - n;
        if (req[3'(idx)]) pick = 3'(idx);
      end
    end
    return pick;
  endfunction

  function automatic logic [2:0] rr_next(
    input logic [2:0] cur,
    input int         n
  );
    return (int'(cur) >= n - 1) ? 3'd0 : cur + 3'd1;
  endfunction

endpackage

// File: rtl/pixel_arbiter.sv
// Round-robin grant over lane outputs; the grant is combinational
// and the pointer parks on the winner while the sink stalls.
module pixel_arbiter
  import render_pkg::*;
#(
  parameter int NUM_LANES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_LANES-1:0] req,
  input  logic                 out_ready,
  output logic [2:0]           grant,
  output logic                 grant_valid,
  output logic [NUM_LANES-1:0] lane_ready
);

  logic [2:0] ptr_q, ptr_d;
  logic [7:0] req8;

  always_comb begin
    req8                 = '0;
    req8[NUM_LANES-1:0]  = req;
    grant       = rr_first(req8, ptr_q, NUM_LANES);
    grant_valid = en && (|req);
    ptr_d       = ptr_q;
    lane_ready  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_ready[k] = en && out_ready && (grant == 3'(k));
    end
    if (grant_valid) begin
      ptr_d = out_ready ? rr_next(grant, NUM_LANES) : grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rasterizer.sv
// Single-primitive lane: emits a horizontal span of len+1 pixels.
// Accepts a new primitive only once the previous span has drained.
module rasterizer
  import render_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  triangle_t   in_prim,
  output logic [15:0] out_x,
  output logic [15:0] out_y,
  output q16_16_t     out_depth,
  output color12_t    out_color,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  triangle_t  prim_q, prim_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;

  always_comb begin
    prim_d = prim_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (!busy_q && in_valid) begin
      prim_d = in_prim;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q && out_ready) begin
      if (cnt_q == prim_q.len) busy_d = 1'b0;
      else cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prim_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      prim_q <= prim_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign in_ready  = !busy_q;
  assign out_valid = busy_q;
  assign busy      = busy_q;
  assign out_x     = prim_q.x + {8'd0, cnt_q};
  assign out_y     = prim_q.y;
  assign out_depth = prim_q.depth;
  assign out_color = prim_q.color;

endmodule

// File: rtl/screen_filler.sv
// Streams every framebuffer pixel in raster order with one colour.
// The colour is latched at start, so later loads wait for the next clear.
module screen_filler
  import render_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  color12_t    color,
  output logic [15:0] out_x,
  output logic [15:0] out_y,
  output color12_t    out_color,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  logic        busy_q, busy_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  color12_t    col_q, col_d;
  logic        x_end;

  always_comb begin
    busy_d = busy_q;
    x_d    = x_q;
    y_d    = y_q;
    col_d  = col_q;
    x_end  = (x_q == 16'(WIDTH - 1));
    if (start && !busy_q) begin
      busy_d = 1'b1;
      x_d    = '0;
      y_d    = '0;
      col_d  = color;
    end else if (busy_q && out_ready) begin
      if (x_end && y_q == 16'(HEIGHT - 1)) begin
        busy_d = 1'b0;
      end else if (x_end) begin
        x_d = '0;
        y_d = y_q + 16'd1;
      end else begin
        x_d = x_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      col_q  <= '0;
    end else begin
      busy_q <= busy_d;
      x_q    <= x_d;
      y_q    <= y_d;
      col_q  <= col_d;
    end
  end

  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_color = col_q;
  assign out_valid = busy_q;
  assign busy      = busy_q;

endmodule

// File: rtl/render_scheduler.sv
// Frame sequencer: optional clear, round-robin triangle dispatch
// to rasterizer lanes, and zero-latency merge of lane pixels.
module render_scheduler
  import render_pkg::*;
#(
  parameter int      WIDTH       = 320,
  parameter int      HEIGHT      = 240,
  parameter int      NUM_LANES   = 2,
  parameter q16_16_t CLEAR_DEPTH = CLEAR_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     begin_frame,
  input  logic                     clear_enable,
  input  logic                     end_frame,
  input  color12_t                 fill_color,
  input  logic                     fill_valid,
  output logic                     fill_ready,
  input  triangle_t                triangle,
  input  logic                     triangle_valid,
  output logic                     triangle_ready,
  output logic [15:0]              out_pixel_x,
  output logic [15:0]              out_pixel_y,
  output q16_16_t                  out_depth,
  output color12_t                 out_color,
  output logic                     out_compare_depth,
  output logic [$clog2(NUM_LANES):0] out_lane,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     frame_done,
  output logic [15:0]              tri_count
);

  localparam int LW = $clog2(NUM_LANES) + 1;

  sched_state_e state_q, state_d;
  color12_t     color_q, color_d;
  logic [15:0]  tri_count_q, tri_count_d;
  logic [2:0]   dptr_q, dptr_d;
  logic [7:0]   rdy8;
  logic [2:0]   dsel;
  logic         accept, f_start, lanes_idle, arb_en;

  logic [15:0] f_x, f_y;
  color12_t    f_color;
  logic        f_valid, f_ready, f_busy;

  logic [NUM_LANES-1:0] ln_in_valid, ln_in_ready;
  logic [NUM_LANES-1:0] ln_out_valid, ln_out_ready, ln_busy;
  logic [15:0]          ln_x [NUM_LANES];
  logic [15:0]          ln_y [NUM_LANES];
  q16_16_t              ln_depth [NUM_LANES];
  color12_t             ln_color [NUM_LANES];

  logic [2:0] a_grant;
  logic       a_valid;

  screen_filler #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_filler (
    .clk      (clk),
    .rst      (rst),
    .start    (f_start),
    .color    (color_q),
    .out_x    (f_x),
    .out_y    (f_y),
    .out_color(f_color),
    .out_valid(f_valid),
    .out_ready(f_ready),
    .busy     (f_busy)
  );

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    rasterizer u_rast (
      .clk      (clk),
      .rst      (rst),
      .in_valid (ln_in_valid[k]),
      .in_ready (ln_in_ready[k]),
      .in_prim  (triangle),
      .out_x    (ln_x[k]),
      .out_y    (ln_y[k]),
      .out_depth(ln_depth[k]),
      .out_color(ln_color[k]),
      .out_valid(ln_out_valid[k]),
      .out_ready(ln_out_ready[k]),
      .busy     (ln_busy[k])
    );
  end

  assign arb_en = (state_q == S_DRAW) || (state_q == S_DRAIN);

  pixel_arbiter #(
    .NUM_LANES(NUM_LANES)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .en         (arb_en),
    .req        (ln_out_valid),
    .out_ready  (out_ready),
    .grant      (a_grant),
    .grant_valid(a_valid),
    .lane_ready (ln_out_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (begin_frame) state_d = clear_enable ? S_CLEAR : S_DRAW;
      S_CLEAR: if (!f_busy) state_d = S_DRAW;
      S_DRAW:  if (end_frame) state_d = S_DRAIN;
      S_DRAIN: if (lanes_idle) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdy8                = '0;
    rdy8[NUM_LANES-1:0] = ln_in_ready;
    dsel           = rr_first(rdy8, dptr_q, NUM_LANES);
    triangle_ready = (state_q == S_DRAW) && (|ln_in_ready);
    accept         = triangle_ready && triangle_valid;
    f_start    = (state_q == S_IDLE) && begin_frame && clear_enable;
    lanes_idle = !(|ln_busy) && !(|ln_out_valid);
    color_d    = fill_valid ? fill_color : color_q;
    dptr_d     = accept ? rr_next(dsel, NUM_LANES) : dptr_q;
    tri_count_d = tri_count_q;
    if (state_q == S_IDLE && begin_frame) begin
      tri_count_d = '0;
    end else if (accept && tri_count_q != 16'hFFFF) begin
      tri_count_d = tri_count_q + 16'd1;
    end
    for (int k = 0; k < NUM_LANES; k++) begin
      ln_in_valid[k] = accept && (dsel == 3'(k));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_q     <= '0;
      tri_count_q <= '0;
      dptr_q      <= '0;
    end else begin
      color_q     <= color_d;
      tri_count_q <= tri_count_d;
      dptr_q      <= dptr_d;
    end
  end

  always_comb begin
    out_pixel_x       = '0;
    out_pixel_y       = '0;
    out_depth         = '0;
    out_color         = '0;
    out_compare_depth = 1'b0;
    out_lane          = '0;
    out_valid         = 1'b0;
    f_ready           = 1'b0;
    busy       = (state_q != S_IDLE);
    frame_done = (state_q == S_DRAIN) && lanes_idle;
    unique case (state_q)
      S_CLEAR: begin
        out_pixel_x = f_x;
        out_pixel_y = f_y;
        out_depth   = CLEAR_DEPTH;
        out_color   = f_color;
        out_lane    = LW'(LANE_FILLER);
        out_valid   = f_valid;
        f_ready     = out_ready;
      end
      S_DRAW, S_DRAIN: begin
        for (int k = 0; k < NUM_LANES; k++) begin
          if (a_grant == 3'(k)) begin
            out_pixel_x = ln_x[k];
            out_pixel_y = ln_y[k];
            out_depth   = ln_depth[k];
            out_color   = ln_color[k];
          end
        end
        out_compare_depth = 1'b1;
        out_lane  = LW'(a_grant) + LW'(LANE_BASE);
        out_valid = a_valid;
      end
      default: ;
    endcase
  end

  assign fill_ready = 1'b1;
  assign tri_count  = tri_count_q;

endmodule

// File: tb/tb_render_scheduler.sv
// Directed bench: clear frame, dispatch order, stall arbitration,
// end_frame with last triangle, and reset mid-frame.
module tb_render_scheduler;
  import render_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        begin_frame = 1'b0;
  logic        clear_enable = 1'b0;
  logic        end_frame = 1'b0;
  color12_t    fill_color = '0;
  logic        fill_valid = 1'b0;
  logic        fill_ready;
  triangle_t   triangle;
  logic        triangle_valid = 1'b0;
  logic        triangle_ready;
  logic [15:0] out_pixel_x, out_pixel_y;
  q16_16_t     out_depth;
  color12_t    out_color;
  logic        out_compare_depth;
  logic [1:0]  out_lane;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy, frame_done;
  logic [15:0] tri_count;

  render_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .begin_frame      (begin_frame),
    .clear_enable     (clear_enable),
    .end_frame        (end_frame),
    .fill_color       (fill_color),
    .fill_valid       (fill_valid),
    .fill_ready       (fill_ready),
    .triangle         (triangle),
    .triangle_valid   (triangle_valid),
    .triangle_ready   (triangle_ready),
    .out_pixel_x      (out_pixel_x),
    .out_pixel_y      (out_pixel_y),
    .out_depth        (out_depth),
    .out_color        (out_color),
    .out_compare_depth(out_compare_depth),
    .out_lane         (out_lane),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .frame_done       (frame_done),
    .tri_count        (tri_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lane;
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] d;
    logic [11:0] c;
    logic        cmp;
  } pix_t;

  pix_t      rx[$];
  triangle_t sent_t[$];
  int        sent_lane[$];

  int   n_chk = 0;
  int   n_fail = 0;
  int   timeouts = 0;
  int   fd_cnt = 0;
  int   rx_at_fd = 0;
  int   stall_err = 0;
  logic mon_on = 1'b0;
  logic prev_stall = 1'b0;
  logic [1:0] prev_lane = '0;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_done) begin
        fd_cnt++;
        rx_at_fd = rx.size();
      end
      if (mon_on) begin
        if (prev_stall && (!out_valid || out_lane != prev_lane))
          stall_err++;
        prev_stall = out_valid && !out_ready;
        prev_lane  = out_lane;
        if (out_valid && out_ready)
          rx.push_back('{int'(out_lane), out_pixel_x, out_pixel_y,
                         out_depth, out_color, out_compare_depth});
      end
    end
  end

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic triangle_t mk_tri(input int i, input logic [7:0] len);
    triangle_t t;
    t.x     = 16'(10 * i + 1);
    t.y     = 16'(i + 5);
    t.len   = len;
    t.depth = 32'(i + 1) << 16;
    t.color = 12'h100 + 12'(i);
    return t;
  endfunction

  task automatic send(input triangle_t t, input int lane, input bit last);
    bit ok;
    ok = 1'b0;
    triangle = t;
    triangle_valid = 1'b1;
    for (int w = 0; w < 200; w++) begin
      if (triangle_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) timeouts++;
    sent_t.push_back(t);
    sent_lane.push_back(lane);
    end_frame = last;
    step();
    triangle_valid = 1'b0;
    end_frame = 1'b0;
  endtask

  task automatic wait_done(input int fdm);
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < 300; w++) begin
      if (fd_cnt > fdm) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) timeouts++;
    repeat (3) step();
  endtask

  task automatic score(input string tag, input int mark);
    int        errs, total, idx;
    triangle_t t;
    errs = 0;
    total = 0;
    for (int l = 0; l < 2; l++) begin
      idx = mark;
      for (int j = 0; j < sent_t.size(); j++) begin
        if (sent_lane[j] == l) begin
          t = sent_t[j];
          for (int p = 0; p <= int'(t.len); p++) begin
            total++;
            while (idx < rx.size() && rx[idx].lane != l + 1) idx++;
            if (idx >= rx.size()) begin
              errs++;
            end else begin
              if (rx[idx].x != t.x + 16'(p) || rx[idx].y != t.y ||
                  rx[idx].d != t.depth || rx[idx].c != t.color ||
                  !rx[idx].cmp)
                errs++;
              idx++;
            end
          end
        end
      end
      while (idx < rx.size()) begin
        if (rx[idx].lane == l + 1) errs++;
        idx++;
      end
    end
    check({tag, "_pixel_count"}, rx.size() - mark, total);
    check({tag, "_scoreboard"}, errs, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, bad, mark, fdm, alt, st0;
    bit  done;
    triangle = '0;

    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_tri_count", tri_count, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_tri_ready", triangle_ready, 0);
    check("fill_ready", fill_ready, 1);
    rst = 1'b0;
    step();
    check("idle_busy", busy, 0);

    fill_color = 12'hF00;
    fill_valid = 1'b1;
    step();
    fill_valid = 1'b0;
    begin_frame = 1'b1;
    clear_enable = 1'b1;
    out_ready = 1'b1;
    step();
    begin_frame = 1'b0;
    clear_enable = 1'b0;
    check("A_busy", busy, 1);
    n = 0;
    bad = 0;
    done = 1'b0;
    for (int c = 0; c < 80000; c++) begin
      if (triangle_ready) begin
        done = 1'b1;
        break;
      end
      if (out_valid) begin
        if (out_lane != 0 || out_color != 12'hF00 ||
            out_depth != 32'h7FFF_FFFF || out_compare_depth ||
            out_pixel_x != 16'(n % 320) || out_pixel_y != 16'(n / 320))
          bad++;
        n++;
      end
      fill_valid = (c == 100);
      fill_color = (c == 100) ? 12'h0A5 : 12'hF00;
      step();
    end
    fill_valid = 1'b0;
    check("A_reached_draw", done, 1);
    check("A_clear_pixels", n, 76800);
    check("A_clear_bad_pixels", bad, 0);
    end_frame = 1'b1;
    step();
    end_frame = 1'b0;
    check("A_frame_done", frame_done, 1);
    step();
    check("A_idle_busy", busy, 0);
    check("A_done_pulses", fd_cnt, 1);

    begin_frame = 1'b1;
    step();
    begin_frame = 1'b0;
    check("B_draw_next", triangle_ready, 1);
    check("B_no_filler", out_valid, 0);
    check("B_tri_count0", tri_count, 0);
    mon_on = 1'b1;
    mark = rx.size();
    fdm = fd_cnt;
    sent_t.delete();
    sent_lane.delete();
    send(mk_tri(0, 8'd0), 0, 1'b0);
    send(mk_tri(1, 8'd1), 1, 1'b0);
    send(mk_tri(2, 8'd2), 0, 1'b0);
    send(mk_tri(3, 8'd3), 1, 1'b1);
    wait_done(fdm);
    check("B_tri_count", tri_count, 4);
    check("B_done_once", fd_cnt - fdm, 1);
    check("B_done_after_drain", rx_at_fd - mark, 10);
    check("B_busy", busy, 0);
    score("B", mark);

    out_ready = 1'b0;
    begin_frame = 1'b1;
    step();
    begin_frame = 1'b0;
    mark = rx.size();
    fdm = fd_cnt;
    st0 = stall_err;
    sent_t.delete();
    sent_lane.delete();
    send(mk_tri(4, 8'd3), 0, 1'b0);
    send(mk_tri(5, 8'd3), 1, 1'b0);
    step();
    check("C_both_full", triangle_ready, 0);
    for (int c = 0; c < 16; c++) begin
      out_ready = (c % 2 == 0);
      step();
    end
    out_ready = 1'b1;
    end_frame = 1'b1;
    step();
    end_frame = 1'b0;
    wait_done(fdm);
    alt = 0;
    for (int k = mark + 1; k < rx.size(); k++)
      if (rx[k].lane == rx[k - 1].lane) alt++;
    check("C_alternate", alt, 0);
    check("C_stall_hold", stall_err - st0, 0);
    check("C_tri_count", tri_count, 2);
    check("C_done_once", fd_cnt - fdm, 1);
    score("C", mark);

    mon_on = 1'b0;
    out_ready = 1'b0;
    begin_frame = 1'b1;
    step();
    begin_frame = 1'b0;
    fdm = fd_cnt;
    send(mk_tri(6, 8'd7), 0, 1'b0);
    step();
    check("D_pending", out_valid, 1);
    check("D_tri_count_pre", tri_count, 1);
    rst = 1'b1;
    #1;
    check("D_rst_out_valid", out_valid, 0);
    check("D_rst_busy", busy, 0);
    check("D_rst_tri_count", tri_count, 0);
    check("D_rst_frame_done", frame_done, 0);
    step();
    check("D_next_out_valid", out_valid, 0);
    check("D_next_busy", busy, 0);
    rst = 1'b0;
    repeat (3) step();
    check("D_no_done_pulse", fd_cnt, fdm);
    check("D_idle_out_valid", out_valid, 0);
    check("D_idle_tri_ready", triangle_ready, 0);
    check("timeouts", timeouts, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/render_scheduler.md
RENDER_SCHEDULER -- requirements
Module: render_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 320, framebuffer width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 240, framebuffer height in pixels.
REQ-003 SHALL have parameter NUM_LANES, default 2, range 1..8, number of internal rasterizer lanes.
REQ-004 SHALL have parameter CLEAR_DEPTH, default 32'h7FFF_FFFF, depth written during clear.
REQ-005 SHALL have ports, in this order:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- begin_frame  in  1  frame start request.
- clear_enable  in  1  sampled with begin_frame; 1 = clear the screen before drawing.
- end_frame  in  1  no more triangles this frame.
- fill_color, fill_valid, fill_ready  in/in/out  12/1/1  clear colour load.
- triangle, triangle_valid, triangle_ready  in/in/out  triangle_t/1/1  triangle input.
- out_pixel_x, out_pixel_y  out  16 each  pixel coordinates.
- out_depth  out  q16_16_t  pixel depth.
- out_color  out  color12_t  pixel colour.
- out_compare_depth  out  1  depth-test enable.
- out_lane  out  $clog2(NUM_LANES)+1  source: 0 = filler, k+1 = lane k.
- out_valid, out_ready  out/in  1/1  pixel handshake.
- busy  out  1  not IDLE.
- frame_done  out  1  one-cycle pulse at frame completion.
- tri_count  out  16  triangles accepted this frame.

Function
REQ-006 SHALL implement the states IDLE, CLEAR, DRAW and DRAIN.
REQ-007 In IDLE, begin_frame=1 SHALL select CLEAR if clear_enable=1 (one-cycle filler start pulse), otherwise DRAW; tri_count SHALL clear to 0.
REQ-008 begin_frame SHALL be ignored outside IDLE.
REQ-009 CLEAR SHALL go to DRAW on the first cycle after the start pulse in which the filler is not busy.
REQ-010 DRAW SHALL go to DRAIN when end_frame=1; a triangle handshaking in the same cycle SHALL still be accepted and counted.
REQ-011 DRAIN SHALL go to IDLE when every lane is not busy and no lane has out_valid; frame_done SHALL be 1 for exactly that transition cycle.
REQ-012 fill_ready SHALL be 1 always; fill_valid SHALL load the colour register; the value loaded during CLEAR SHALL take effect from the next clear.
REQ-013 triangle_ready SHALL be (state==DRAW) AND (any lane in_ready).
REQ-014 Dispatch SHALL be round-robin: the accepted triangle goes to the first ready lane at or after the dispatch pointer, and the pointer SHALL then move to that lane+1 mod NUM_LANES.
REQ-015 Only the selected lane SHALL see in_valid.
REQ-016 tri_count SHALL increment on each accepted triangle and saturate at 16'hFFFF.
REQ-017 In CLEAR, the output SHALL carry filler pixels with out_depth=CLEAR_DEPTH, out_compare_depth=0 and out_lane=0.
REQ-018 In DRAW and DRAIN, the output SHALL come from a round-robin arbiter over lane out_valid, with out_compare_depth=1.
REQ-019 The arbiter grant SHALL be held while out_valid=1 and out_ready=0; it SHALL switch only after a transfer or when the granted lane has no valid output.
REQ-020 Each lane's out_ready SHALL be out_ready AND (grant==lane); un-granted lanes SHALL stall.
REQ-021 Output data SHALL be combinational from the granted source, so the scheduler adds zero latency.
REQ-022 In IDLE, out_valid SHALL be 0.

Reset
REQ-023 Reset SHALL set the state to IDLE, the dispatch and grant pointers to 0, tri_count to 0, frame_done to 0, the colour register to 0 and busy to 0.
REQ-024 Reset mid-frame SHALL abort immediately with no frame_done pulse, and the sub-blocks SHALL reset in the same cycle.

Structure
REQ-025 The state enum, the out_lane encoding and CLEAR_DEPTH's default SHALL live in the shared render package, alongside triangle_t, color12_t and q16_16_t.
REQ-026 The round-robin output arbiter SHALL be the sub-module pixel_arbiter, parametrised by NUM_LANES.
REQ-027 The design SHALL reuse the existing screen_filler and rasterizer blocks unchanged.

Verification
REQ-028 begin_frame with clear_enable=1, fill_color=12'hF00, out_ready=1 -> exactly 76800 pixels, all out_lane=0, colour F00, depth 7FFF_FFFF, then state DRAW.
REQ-029 begin_frame with clear_enable=0 -> DRAW next cycle and no filler pixels.
REQ-030 NUM_LANES=2 with four triangles back-to-back -> dispatched to lanes 0,1,0,1 and tri_count=4.
REQ-031 Both lanes valid and out_ready toggling 1,0,1,0 -> grant is stable during each stall and lanes alternate, with no pixel lost or duplicated against a reference model.
REQ-032 end_frame asserted in the same cycle as the last triangle handshake -> that triangle is counted, and frame_done pulses once only after all of its pixels drain.
REQ-033 rst asserted mid-DRAW with pixels pending -> next cycle out_valid=0, busy=0, tri_count=0, and no frame_done pulse.
